// File: rtl/fixdiv_iter_param_if.sv
// Handshake and operand/result bundle for the iterative fixed-point divider.
// The requester drives operands and start; the divider returns status and the quotient.
interface fixdiv_iter_param_if #(
  parameter int W   = 64,
  parameter int EXT = 16,
  parameter int DPW = 7
);
  logic               start;
  logic [W-1:0]       dividend;
  logic [W-1:0]       divisor;
  logic               sign_dvd;
  logic               sign_dvs;
  logic [DPW-1:0]     dotplace_dvd;
  logic [DPW-1:0]     dotplace_dvs;
  logic               busy;
  logic               done;
  logic [W+EXT-1:0]   result;
  logic               signresult;
  logic [DPW+1:0]     dotplaceresult;
  logic               divzero;

  modport master (
    output start, dividend, divisor, sign_dvd, sign_dvs, dotplace_dvd, dotplace_dvs,
    input  busy, done, result, signresult, dotplaceresult, divzero
  );

  modport slave (
    input  start, dividend, divisor, sign_dvd, sign_dvs, dotplace_dvd, dotplace_dvs,
    output busy, done, result, signresult, dotplaceresult, divzero
  );
endinterface

// File: rtl/fixdiv_iter_param.sv
// Radix-2 restoring sign-magnitude fixed-point divider, one quotient bit per cycle,
// with EXT extra fraction bits, divide-by-zero flag and back-to-back start on the done cycle.
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | shifting out one quotient bit per cycle, cnt counts QW-1 down to 0
// S_DONE | done pulse; a start here is accepted exactly as in S_IDLE
module fixdiv_iter_param #(
  parameter int W   = 64,
  parameter int EXT = 16,
  parameter int DPW = 7
) (
  input  logic                 systclk,
  input  logic                 init,
  fixdiv_iter_param_if.slave   bus
);
  localparam int QW = W + EXT;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [DPW+1:0] EXT_DP = (DPW+2)'(EXT);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [W:0]        rem;
  logic [QW-1:0]     quo;
  logic [W-1:0]      dvs_r;
  logic              sgn_r;
  logic [DPW+1:0]    dp_r;

  logic [W+1:0]      rem_sh;
  logic [W+1:0]      diff;
  logic              ge;
  logic [W:0]        rem_nx;
  logic [QW-1:0]     quo_nx;
  logic [DPW+1:0]    dp_in;

  // quo doubles as dividend shifter and quotient accumulator: bits leave at the
  // top into the remainder while new quotient bits enter at the bottom.
  always_comb begin
    rem_sh = {rem, quo[QW-1]};
    diff   = rem_sh - {2'b00, dvs_r};
    ge     = ~diff[W+1];
    rem_nx = ge ? diff[W:0] : rem_sh[W:0];
    quo_nx = {quo[QW-2:0], ge};
    dp_in  = {2'b00, bus.dotplace_dvd} + EXT_DP - {2'b00, bus.dotplace_dvs};
  end

  always_ff @(posedge systclk) begin
    if (!init) begin
      state              <= S_IDLE;
      cnt                <= '0;
      rem                <= '0;
      quo                <= '0;
      dvs_r              <= '0;
      sgn_r              <= 1'b0;
      dp_r               <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.result         <= '0;
      bus.signresult     <= 1'b0;
      bus.dotplaceresult <= '0;
      bus.divzero        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              bus.done           <= 1'b1;
              bus.result         <= '1;
              bus.divzero        <= 1'b1;
              bus.signresult     <= bus.sign_dvd ^ bus.sign_dvs;
              bus.dotplaceresult <= dp_in;
              state              <= S_DONE;
            end else begin
              bus.busy <= 1'b1;
              rem      <= '0;
              quo      <= QW'(bus.dividend) << EXT;
              dvs_r    <= bus.divisor;
              sgn_r    <= bus.sign_dvd ^ bus.sign_dvs;
              dp_r     <= dp_in;
              cnt      <= CW'(QW - 1);
              state    <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.busy           <= 1'b0;
            bus.done           <= 1'b1;
            bus.result         <= quo_nx;
            bus.signresult     <= sgn_r & (|quo_nx);
            bus.divzero        <= 1'b0;
            bus.dotplaceresult <= dp_r;
            state              <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixdiv_iter_param.sv
// Scoreboard bench for fixdiv_iter_param: expected quotients are queued at issue
// and compared whenever the divider pulses done; latency and busy length are checked per op.
module tb_fixdiv_iter_param;
  localparam int W   = 64;
  localparam int EXT = 16;
  localparam int DPW = 7;
  localparam int QW  = W + EXT;

  typedef struct packed {
    logic [QW-1:0]  res;
    logic           sg;
    logic [DPW+1:0] dp;
    logic           dz;
  } exp_t;

  logic systclk;
  logic init;
  int   n_cmp;
  int   n_err;
  exp_t sbq[$];

  fixdiv_iter_param_if #(.W(W), .EXT(EXT), .DPW(DPW)) bus ();

  fixdiv_iter_param #(.W(W), .EXT(EXT), .DPW(DPW)) dut (
    .systclk (systclk),
    .init    (init),
    .bus     (bus)
  );

  initial systclk = 1'b0;
  always #5 systclk = ~systclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                 input logic sd, input logic ss,
                                 input logic [DPW-1:0] dpd, input logic [DPW-1:0] dps);
    exp_t e;
    int   d;
    logic [QW-1:0] num;
    d    = int'(dpd) + EXT - int'(dps);
    e.dp = d[DPW+1:0];
    if (dvs == '0) begin
      e.res = '1;
      e.dz  = 1'b1;
      e.sg  = sd ^ ss;
    end else begin
      num   = QW'(dvd) << EXT;
      e.res = num / QW'(dvs);
      e.dz  = 1'b0;
      e.sg  = (sd ^ ss) && (e.res != '0);
    end
    return e;
  endfunction

  always @(negedge systclk) begin
    if (init && bus.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result",     bus.result,         e.res);
        chk("signresult", bus.signresult,     e.sg);
        chk("dotplace",   bus.dotplaceresult, e.dp);
        chk("divzero",    bus.divzero,        e.dz);
        chk("busy_at_done", bus.busy,         0);
      end
    end
  end

  // Called just after a falling edge; the start is accepted on the next rising edge.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic sd, input logic ss,
                       input logic [DPW-1:0] dpd, input logic [DPW-1:0] dps);
    bus.dividend     = dvd;
    bus.divisor      = dvs;
    bus.sign_dvd     = sd;
    bus.sign_dvs     = ss;
    bus.dotplace_dvd = dpd;
    bus.dotplace_dvs = dps;
    bus.start        = 1'b1;
    sbq.push_back(model(dvd, dvs, sd, ss, dpd, dps));
    @(posedge systclk);
    #1 bus.start = 1'b0;
  endtask

  // Counts falling edges after the accepting edge until done; also counts busy cycles.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int k;
    int nb;
    k  = 0;
    nb = 0;
    do begin
      @(negedge systclk);
      k++;
      if (bus.busy) nb++;
    end while (!bus.done && k < 300);
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_busy"}, nb, exp_busy);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    init  = 1'b0;
    bus.start = 1'b1;
    bus.dividend = 64'd3;
    bus.divisor  = 64'd1;
    bus.sign_dvd = 1'b0;
    bus.sign_dvs = 1'b0;
    bus.dotplace_dvd = '0;
    bus.dotplace_dvs = '0;
    repeat (3) @(negedge systclk);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_done",   bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_dp",     bus.dotplaceresult, 0);
    chk("rst_dz",     bus.divzero, 0);
    bus.start = 1'b0;
    init = 1'b1;
    repeat (2) @(negedge systclk);
    chk("rst_start_ignored", bus.busy, 0);

    // 1) unity ratio
    issue(64'h0020_0000_0000_0000, 64'h0020_0000_0000_0000, 0, 0, 7'd53, 7'd53);
    wait_done("t1", QW + 1, QW);
    @(negedge systclk);

    // 2) 7/2 with negative dividend, then outputs hold while inputs change
    issue(64'd7, 64'd2, 1, 0, 7'd0, 7'd0);
    wait_done("t2", QW + 1, QW);
    repeat (3) @(negedge systclk);
    bus.dividend = 64'd1234;
    bus.divisor  = 64'd0;
    @(negedge systclk);
    chk("t2_hold", bus.result, 80'h38000);
    chk("t2_hold_done", bus.done, 0);

    // 3) divide by zero
    issue(64'd5, 64'd0, 1, 0, 7'd3, 7'd10);
    wait_done("t3", 1, 0);
    @(negedge systclk);

    // 4) zero dividend: no negative zero
    issue(64'd0, 64'd9, 1, 0, 7'd0, 7'd100);
    wait_done("t4", QW + 1, QW);
    @(negedge systclk);

    // 5) start during busy is ignored, then back-to-back start on the done cycle
    issue(64'd1000, 64'd3, 0, 1, 7'd4, 7'd2);
    repeat (9) @(negedge systclk);
    bus.dividend = 64'hFFFF;
    bus.divisor  = 64'd1;
    bus.start    = 1'b1;
    @(negedge systclk);
    bus.start    = 1'b0;
    begin
      int k;
      k = 10;
      while (!bus.done && k < 300) begin
        @(negedge systclk);
        k++;
      end
      chk("t5_first_latency", k, QW + 1);
    end
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 1, 7'd127, 7'd0);
    wait_done("t5_b2b", QW + 1, QW);
    @(negedge systclk);

    // 6) reset mid-CALC aborts without done, then a fresh op completes
    issue(64'd99, 64'd7, 1, 0, 7'd5, 7'd5);
    repeat (39) @(negedge systclk);
    init = 1'b0;
    @(negedge systclk);
    init = 1'b1;
    sbq.delete();
    chk("t6_busy",   bus.busy, 0);
    chk("t6_result", bus.result, 0);
    chk("t6_sign",   bus.signresult, 0);
    chk("t6_dp",     bus.dotplaceresult, 0);
    begin
      int seen;
      seen = 0;
      repeat (100) begin
        @(negedge systclk);
        if (bus.done) seen++;
      end
      chk("t6_no_done", seen, 0);
    end
    issue(64'd99, 64'd7, 1, 0, 7'd5, 7'd5);
    wait_done("t6_fresh", QW + 1, QW);
    @(negedge systclk);

    // random operands, including divisor larger than dividend and negative binary points
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 62);
      if (b == '0) b = 64'd13;
      issue(a, b, 1'($urandom), 1'($urandom), 7'($urandom), 7'($urandom));
      wait_done("rand", QW + 1, QW);
    end
    @(negedge systclk);
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
